stage_skid_reg: RTL

//   Parametrised inter-stage pipeline register (IFU->IDU->EXU->LSU->WBU) with full valid/ready handshake.

---
 rtl/stage_pkg.sv | 49 ++++
 rtl/stage_skid_reg_sat_cnt.sv | 37 +++
 rtl/stage_skid_reg.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/stage_pkg.sv
// -----------------------------------------------------------------------------
// stage_pkg
//   Shared types for the inter-stage pipeline registers.
//   - stage_state_e : occupancy state of one skid stage (empty / one / two held)
//   - per-boundary payload structs; a stage instance sets DATA_W from $bits()
//     of the struct it carries and packs/unpacks the vector at its boundary.
// -----------------------------------------------------------------------------
package stage_pkg;

    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_BUSY  = 2'd1,
        STG_FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ifu2idu_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [15:0] ctrl;
    } idu2exu_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] store_data;
        logic [15:0] ctrl;
    } exu2lsu_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        wb_en;
    } lsu2wbu_t;

    localparam int IFU2IDU_W = $bits(ifu2idu_t);
    localparam int IDU2EXU_W = $bits(idu2exu_t);
    localparam int EXU2LSU_W = $bits(exu2lsu_t);
    localparam int LSU2WBU_W = $bits(lsu2wbu_t);

endpackage

// File: rtl/stage_skid_reg_sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
//   Saturating up-counter used for the downstream-stall statistic of
//   stage_skid_reg. Only compiled when STAGE_SKID_STALL_CNT_EN is defined, so
//   the default build carries no stray top-level module.
// Ports
//   i_sys_clk    in   1      clock
//   i_sys_rst_n  in   1      asynchronous active-low reset, clears the count
//   inc          in   1      count one event this cycle
//   clr          in   1      synchronous clear (wins over inc)
//   out          out  CNT_W  current count, sticks at all-ones
// -----------------------------------------------------------------------------
`ifdef STAGE_SKID_STALL_CNT_EN
module sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] out
);

    // Count up on inc until every bit is set, then hold there; only reset or
    // an explicit clr bring it back to zero.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            out <= '0;
        end else if (clr) begin
            out <= '0;
        end else if (inc && (out != '1)) begin
            out <= out + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/stage_skid_reg.sv
// -----------------------------------------------------------------------------
// stage_skid_reg
//   Inter-stage pipeline register with a full valid/ready handshake and a
//   two-entry skid buffer: sustains one transfer per cycle while o_pre_ready
//   is a pure register decode (no combinational path from i_nxt_ready).
//   Payload goes to downstream from the main register only; the skid register
//   catches the one extra beat accepted while downstream stalls.
// Optional feature
//   STAGE_SKID_STALL_CNT_EN : adds o_stall_cnt, a saturating count of cycles
//                             with o_nxt_valid & !i_nxt_ready (reset clears it,
//                             flush does not).
// Ports
//   i_sys_clk    in   1       clock, all state on posedge
//   i_sys_rst_n  in   1       asynchronous active-low reset
//   i_flush      in   1       synchronous flush, drops all held entries
//   i_pre_valid  in   1       upstream payload valid
//   o_pre_ready  out  1       this stage can accept
//   i_pre_data   in   DATA_W  upstream payload
//   o_nxt_valid  out  1       payload valid to downstream
//   i_nxt_ready  in   1       downstream accepts
//   o_nxt_data   out  DATA_W  payload to downstream
//   o_stall_cnt  out  CNT_W   stall cycle count (macro builds only)
// -----------------------------------------------------------------------------
module stage_skid_reg #(
    parameter int                DATA_W  = 128,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = 32
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_flush,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    input  logic [DATA_W-1:0] i_pre_data,
    output logic              o_nxt_valid,
    input  logic              i_nxt_ready,
    output logic [DATA_W-1:0] o_nxt_data
`ifdef STAGE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

    import stage_pkg::*;

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    // Both handshake outputs come straight from the state register so that
    // neither side sees a combinational path through this stage.
    assign o_nxt_valid = (state_q != STG_EMPTY);
    assign o_pre_ready = (state_q != STG_FULL);
    assign o_nxt_data  = main_q;

    assign in_fire  = i_pre_valid & o_pre_ready;
    assign out_fire = o_nxt_valid & i_nxt_ready;

    // Occupancy FSM plus the register-load strobes. The main register always
    // holds the oldest entry; the skid register only ever holds the second.
    // A flush forces EMPTY and suppresses every load, so the beat offered in
    // the flush cycle is dropped and the stale data simply stays put.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            STG_EMPTY: begin
                if (in_fire) begin
                    state_d      = STG_BUSY;
                    load_main_in = 1'b1;
                end
            end
            STG_BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = STG_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = STG_EMPTY;
                end
            end
            STG_FULL: begin
                if (out_fire) begin
                    state_d        = STG_BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = STG_EMPTY;
            end
        endcase
        if (i_flush) begin
            state_d        = STG_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State register; reset discards anything in flight.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q <= STG_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers only move on an accepted beat or a skid promotion,
    // which keeps o_nxt_data stable during stalls and keeps unaccepted
    // (possibly X) upstream data out of the stage.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            if (load_main_in) begin
                main_q <= i_pre_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= i_pre_data;
            end
        end
    end

`ifdef STAGE_SKID_STALL_CNT_EN
    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_sys_clk   (i_sys_clk),
        .i_sys_rst_n (i_sys_rst_n),
        .inc         (o_nxt_valid & ~i_nxt_ready),
        .clr         (1'b0),
        .out         (o_stall_cnt)
    );
`else
    // Keeps CNT_W referenced when the counter is compiled out.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
